// File: rtl/vga_pkg.sv
// Shared VGA ROM-arbiter types and default widths.
package vga_pkg;

  localparam int unsigned ROM_AW_DEF = 11;
  localparam int unsigned ROM_DW_DEF = 8;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_DISP = 2'd1,
    TAG_AUX  = 2'd2
  } arb_tag_t;

endpackage : vga_pkg

// File: rtl/vga_tag_pipe.sv
// Shift register tracking the owner of each in-flight ROM read.
module vga_tag_pipe
  import vga_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  arb_tag_t tag_in,
  output arb_tag_t tag_out
);

  arb_tag_t stages [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stages[i] <= TAG_NONE;
      end
    end else begin
      stages[0] <= tag_in;
      for (int i = 1; i < int'(DEPTH); i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign tag_out = stages[DEPTH-1];

endmodule : vga_tag_pipe

// File: rtl/vga_rom_arbiter.sv
// Shares one synchronous ROM between the display pipeline (priority) and an aux port.
// Optional wait-cycle statistics via VGA_ROM_ARB_STATS_EN.
module vga_rom_arbiter
  import vga_pkg::*;
#(
  parameter int unsigned ROM_AW  = ROM_AW_DEF,
  parameter int unsigned ROM_DW  = ROM_DW_DEF,
  parameter int unsigned ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_req,
  input  logic [ROM_AW-1:0] disp_addr,
  output logic              disp_rvalid,
  output logic [ROM_DW-1:0] disp_rdata,
  input  logic              aux_req,
  input  logic [ROM_AW-1:0] aux_addr,
  output logic              aux_gnt,
  output logic              aux_rvalid,
  output logic [ROM_DW-1:0] aux_rdata,
`ifdef VGA_ROM_ARB_STATS_EN
  input  logic              stats_clr,
  output logic [15:0]       aux_wait_cnt,
`endif
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [ROM_DW-1:0] rom_data
);

  localparam int unsigned PIPE_DEPTH = ROM_LAT + 1;

  arb_tag_t          issue_tag;
  arb_tag_t          ret_tag;
  logic [ROM_AW-1:0] issue_addr;

  // Display wins outright; aux only gets cycles the display leaves idle.
  always_comb begin
    aux_gnt    = 1'b0;
    issue_tag  = TAG_NONE;
    issue_addr = disp_addr;
    if (rst_n) begin
      if (disp_req) begin
        issue_tag  = TAG_DISP;
        issue_addr = disp_addr;
      end else if (aux_req) begin
        aux_gnt    = 1'b1;
        issue_tag  = TAG_AUX;
        issue_addr = aux_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr <= '0;
    end else if (issue_tag != TAG_NONE) begin
      rom_addr <= issue_addr;
    end
  end

  vga_tag_pipe #(
    .DEPTH (PIPE_DEPTH)
  ) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (issue_tag),
    .tag_out (ret_tag)
  );

  // Route returned ROM byte to whichever port owns the tag at the final stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_rvalid <= 1'b0;
      disp_rdata  <= '0;
      aux_rvalid  <= 1'b0;
      aux_rdata   <= '0;
    end else begin
      disp_rvalid <= (ret_tag == TAG_DISP);
      aux_rvalid  <= (ret_tag == TAG_AUX);
      if (ret_tag == TAG_DISP) begin
        disp_rdata <= rom_data;
      end
      if (ret_tag == TAG_AUX) begin
        aux_rdata <= rom_data;
      end
    end
  end

`ifdef VGA_ROM_ARB_STATS_EN
  localparam logic [15:0] WAIT_MAX = 16'hFFFF;

  // Saturating count of cycles aux is held off; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aux_wait_cnt <= '0;
    end else if (stats_clr) begin
      aux_wait_cnt <= '0;
    end else if (aux_req && !aux_gnt && (aux_wait_cnt != WAIT_MAX)) begin
      aux_wait_cnt <= aux_wait_cnt + 16'd1;
    end
  end
`endif

endmodule : vga_rom_arbiter

// File: doc/vga_rom_arbiter.md
Name: vga_rom_arbiter

Overview:
- Shares the single-port character/pattern ROM (11-bit address, 8-bit data, synchronous read) between two requesters.
  - Display pipeline: fixed-latency, strict priority.
  - Auxiliary requester: e.g. a text-buffer loader or debug reader, served in leftover cycles.
- Sits between the VGA pixel-control pipeline and the ROM, replacing the direct rom_addr hookup.
- Tags every in-flight read so each returned byte is routed back to the requester that issued it.

Parameters:
ROM_AW, 11, ROM address width
ROM_DW, 8, ROM data width
ROM_LAT, 1, clock edges from ROM sampling rom_addr to rom_data valid (1..3)

Ports:
clk  input  1  system pixel clock
rst_n  input  1  asynchronous active-low reset
disp_req  input  1  display read request, one read per cycle when high
disp_addr  input  ROM_AW  display read address, sampled with disp_req
disp_rvalid  output  1  display read data valid strobe
disp_rdata  output  ROM_DW  display read data
aux_req  input  1  auxiliary read request (level)
aux_addr  input  ROM_AW  auxiliary address, held stable while aux_req high and aux_gnt low
aux_gnt  output  1  auxiliary request accepted this cycle (combinational)
aux_rvalid  output  1  auxiliary read data valid strobe
aux_rdata  output  ROM_DW  auxiliary read data
rom_addr  output  ROM_AW  address to ROM (registered)
rom_data  input  ROM_DW  data from ROM

Behaviour:
- Reset (async, rst_n low):
  - rom_addr=0, disp_rvalid=0, disp_rdata=0, aux_rvalid=0, aux_rdata=0.
  - Tag pipeline cleared to NONE.
  - aux_gnt=0 while rst_n low.
- Arbitration, evaluated each cycle:
  - disp_req=1: issue display read; aux_gnt=0.
  - disp_req=0 and aux_req=1: aux_gnt=1, issue aux read.
  - Neither: no issue; tag NONE; rom_addr holds its last value.
- Issue at edge k:
  - rom_addr <= selected address.
  - Tag (DISP/AUX/NONE) enters the tag pipeline.
- Latency:
  - rdata register captures rom_data on the edge where the tag reaches depth ROM_LAT+1.
  - The matching rvalid is high for exactly that following cycle.
  - Request-to-rvalid latency LAT = ROM_LAT+2 cycles (3 at default) for both ports, constant.
- Throughput: one read per cycle total; back-to-back reads from either port allowed.
- Aux handshake:
  - Each cycle with aux_req=1 and aux_gnt=1 is one transfer.
  - The requester advances aux_addr or drops aux_req after each gnt.
  - aux_req held high with gnt high issues repeated reads, one per cycle.
- rdata holds its last value when the matching rvalid=0. Only the tagged port's rdata updates.
- Simultaneous requests: display always wins. Aux waits with no timeout; starvation during continuous active video is acceptable because blanking frees the ROM.
- disp_req toggling every cycle interleaves DISP/AUX issues; tags keep returned order exact.
- Reset mid-operation: all in-flight tags are discarded; no rvalid is produced for reads issued before reset.
- No internal FIFO: requesters must accept rvalid unconditionally (no backpressure).

Optional Feature:
- Macro: VGA_ROM_ARB_STATS_EN.
- Defined:
  - Adds input stats_clr (1 bit) and output aux_wait_cnt (16 bits).
  - Counter increments each cycle aux_req=1 and aux_gnt=0.
  - Saturates at 16'hFFFF.
  - Cleared by reset or stats_clr=1; clear wins over increment in the same cycle.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Shared package vga_pkg:
  - Constants ROM_AW_DEF=11, ROM_DW_DEF=8.
  - Tag typedef arb_tag_t, 2-bit: TAG_NONE=0, TAG_DISP=1, TAG_AUX=2.
- One natural sub-module: vga_tag_pipe.
  - Parameterised depth ROM_LAT+1 shift register of arb_tag_t.
  - Async reset to TAG_NONE.
  - Outputs the tag at the final stage.

Test Plan:
- Reset release, no requests -> all rvalid stay 0 for 20 cycles; rom_addr=0.
- disp_req=1, addr 0x010..0x01F for 16 consecutive cycles; ROM model returns addr[7:0] -> disp_rvalid high for 16 consecutive cycles starting 3 cycles after the first request; disp_rdata 0x10..0x1F in order; aux_rvalid never high.
- aux_req=1, addr=0x123 while disp_req=1 for 5 cycles, then disp_req=0 -> aux_gnt=0 for the 5 cycles; gnt=1 on cycle 6; aux_rvalid with aux_rdata=0x23 three cycles later.
- disp_req alternating 1/0 with aux_req held high, aux addr incrementing from 0x200 per gnt -> strictly interleaved DISP/AUX rvalids; each rdata matches its own issued address; no cross-routing.
- Assert rst_n=0 for one cycle while 2 reads are in flight -> no rvalid for those reads; the next request after release returns correctly at latency 3.
- VGA_ROM_ARB_STATS_EN: aux blocked 70000 cycles -> aux_wait_cnt=16'hFFFF; stats_clr pulse -> 0 next cycle.
